// File: rtl/hack_la_rom_loader.sv
// Logic-analyzer driven loader for the Hack SoC program ROM: firmware toggles
// LA strobes, words are buffered in a small FIFO and streamed to the ROM write port.
module hack_la_rom_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              active,
    input  logic [31:0]       la1_data_in,
    input  logic [31:0]       la1_oenb,
    output logic [31:0]       la1_data_out,
    output logic              load_valid,
    output logic [ADDR_W-1:0] load_addr,
    output logic [DATA_W-1:0] load_data,
    input  logic              load_ready,
    output logic              load_active
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         hist_q;
    logic               ev_strobe, ev_start, ev_done;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               overflow_q;
    logic               fifo_empty, fifo_full;
    logic               head_valid, pop, flush, push_req, push_ok, drop;
    logic [DATA_W-1:0]  push_word;
    logic               unused_inputs;

    // Only the word, strobe, start and done bits carry meaning.
    assign unused_inputs = ^{la1_oenb, la1_data_in[31:19]};

    // Event history: loaded from the live inputs in reset and tracked even while
    // inactive, so neither reset release nor re-activation produces an event.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            // NOTE: sequential state always uses non-blocking assignments so every
            // register samples pre-edge values regardless of process ordering.
            hist_q <= la1_data_in[18:16];
        end else begin
            hist_q <= la1_data_in[18:16];
        end
    end

    assign ev_strobe = la1_data_in[16] ^ hist_q[0];
    assign ev_start  = la1_data_in[17] ^ hist_q[1];
    assign ev_done   = la1_data_in[18] ^ hist_q[2];
    assign push_word = DATA_W'(la1_data_in[15:0]);

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign head_valid = active && (state_q != ST_IDLE) && !fifo_empty;
    assign pop        = head_valid && load_ready && !flush;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no
        // path through the case leaves it unassigned (which would infer a latch).
        state_d  = state_q;
        flush    = 1'b0;
        push_req = 1'b0;
        if (active) begin
            if (ev_start) begin
                flush   = 1'b1;
                state_d = ST_LOAD;
            end else begin
                unique case (state_q)
                    ST_IDLE: ;
                    ST_LOAD: begin
                        push_req = ev_strobe;
                        if (ev_done) state_d = ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        // Leave as soon as the last word goes out so load_active
                        // drops in the very next cycle.
                        if (fifo_empty || (level_q == LVL_W'(1) && pop)) state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // A push into a full FIFO only fits when the head leaves on the same edge.
    assign push_ok = push_req && (!fifo_full || pop);
    assign drop    = push_req && fifo_full && !pop;

    always_ff @(posedge wb_clk_i) begin
        // NOTE: the storage array carries no reset; the level counter alone
        // decides which entries are meaningful, so stale contents are harmless.
        if (push_ok) mem[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                addr_q   <= addr_q + ADDR_W'(1);
            end
            if (push_ok && !pop)      level_q <= level_q + LVL_W'(1);
            else if (pop && !push_ok) level_q <= level_q - LVL_W'(1);
            if (drop) overflow_q <= 1'b1;
        end
    end

    assign load_valid  = head_valid;
    assign load_active = active && (state_q != ST_IDLE);
    assign load_addr   = active ? addr_q : '0;
    assign load_data   = head_valid ? mem[rd_ptr_q] : '0;

    always_comb begin
        la1_data_out = '0;
        if (active) begin
            la1_data_out = {10'd0, fifo_full, 3'(level_q), state_q, overflow_q, 15'(addr_q)};
        end
    end

endmodule

// File: tb/tb_hack_la_rom_loader.sv
// Directed and randomized bench for hack_la_rom_loader; a queue-based model of the
// loader predicts every ROM write and the LA status word cycle by cycle.
`timescale 1ns/1ps
module tb_hack_la_rom_loader;

    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 16;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_n;
    logic              active;
    logic [31:0]       la1_data_in;
    logic [31:0]       la1_oenb;
    logic [31:0]       la1_data_out;
    logic              load_valid;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_active;

    int total = 0;
    int bad   = 0;

    // model state: 0 idle, 1 loading, 2 draining
    int          m_state;
    logic [15:0] mq[$];
    logic [14:0] m_addr;
    logic        m_ovf;
    logic [2:0]  m_hist;
    logic [30:0] log_q[$];

    hack_la_rom_loader #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_n    (wb_rst_n),
        .active      (active),
        .la1_data_in (la1_data_in),
        .la1_oenb    (la1_oenb),
        .la1_data_out(la1_data_out),
        .load_valid  (load_valid),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .load_active (load_active)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [30:0] get_log(input int idx);
        if (idx < 0 || idx >= log_q.size()) return 31'h7FFF_FFFF;
        return log_q[idx];
    endfunction

    // Reference model: evaluated mid-cycle on the values that the next rising edge will see.
    always @(negedge wb_clk_i) begin : model
        logic [2:0]  cur, ev;
        logic        exp_act, exp_valid, pop;
        logic [31:0] exp_status;
        cur = la1_data_in[18:16];
        if (!wb_rst_n) begin
            m_state = 0;
            mq.delete();
            m_addr = '0;
            m_ovf  = 1'b0;
            m_hist = cur;
            check("rst_valid", load_valid, 0);
            check("rst_status", la1_data_out, 0);
        end else begin
            ev     = cur ^ m_hist;
            m_hist = cur;
            exp_act    = active && (m_state != 0);
            exp_valid  = exp_act && (mq.size() != 0);
            exp_status = active ? {10'd0, mq.size() == FIFO_DEPTH, 3'(mq.size()), 2'(m_state), m_ovf, m_addr}
                                : 32'd0;
            check("valid", load_valid, exp_valid);
            check("active_out", load_active, exp_act);
            check("status", la1_data_out, exp_status);
            if (exp_valid) begin
                check("addr", load_addr, m_addr);
                check("data", load_data, mq[0]);
            end
            if (load_valid && load_ready) log_q.push_back({load_addr, load_data});
            if (active) begin
                pop = exp_valid && load_ready;
                if (ev[1]) begin
                    mq.delete();
                    m_addr  = '0;
                    m_ovf   = 1'b0;
                    m_state = 1;
                end else begin
                    if (pop) begin
                        void'(mq.pop_front());
                        m_addr = m_addr + 15'd1;
                    end
                    if (m_state == 1) begin
                        if (ev[0]) begin
                            if (mq.size() < FIFO_DEPTH) mq.push_back(la1_data_in[15:0]);
                            else m_ovf = 1'b1;
                        end
                        if (ev[2]) m_state = 2;
                    end else if (m_state == 2 && mq.size() == 0) begin
                        m_state = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Toggle one LA control bit (16 strobe, 17 start, 18 done) with a word alongside.
    task automatic pulse(input int bitn, input logic [15:0] word);
        la1_data_in[15:0]  = word;
        la1_data_in[bitn]  = ~la1_data_in[bitn];
        la1_data_in[31:19] = 13'($urandom);
        tick();
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!load_active) break;
            tick();
        end
        check("drain_timeout", load_active, 0);
    endtask

    initial begin
        int n0;
        wb_rst_n    = 1'b0;
        active      = 1'b1;
        load_ready  = 1'b1;
        la1_data_in = $urandom;
        la1_oenb    = $urandom;
        #1;
        check("reset_valid", load_valid, 0);
        check("reset_status", la1_data_out, 0);
        repeat (3) tick();
        wb_rst_n = 1'b1;
        repeat (2) tick();
        check("post_reset_idle", la1_data_out, 0);

        // basic load
        n0 = log_q.size();
        pulse(17, 16'h0);
        pulse(16, 16'h1234);
        pulse(16, 16'hABCD);
        pulse(16, 16'h0007);
        pulse(18, 16'h0);
        wait_idle(50);
        check("basic_count", log_q.size() - n0, 3);
        check("basic_w0", get_log(n0),     {15'd0, 16'h1234});
        check("basic_w1", get_log(n0 + 1), {15'd1, 16'hABCD});
        check("basic_w2", get_log(n0 + 2), {15'd2, 16'h0007});
        check("basic_status", la1_data_out, 32'h0000_0003);

        // backpressure and overflow
        load_ready = 1'b0;
        n0 = log_q.size();
        pulse(17, 16'h0);
        for (int i = 1; i <= 5; i++) pulse(16, 16'(i));
        check("bp_status", la1_data_out, 32'h0031_8000);
        load_ready = 1'b1;
        pulse(18, 16'h0);
        wait_idle(50);
        check("bp_count", log_q.size() - n0, 4);
        for (int i = 0; i < 4; i++) check("bp_word", get_log(n0 + i), {15'(i), 16'(i + 1)});

        // push and pop on the same edge with a full FIFO
        load_ready = 1'b0;
        n0 = log_q.size();
        pulse(17, 16'h0);
        for (int i = 0; i < 4; i++) pulse(16, 16'h0010 + 16'(i));
        check("full_status", la1_data_out, 32'h0031_0000);
        load_ready = 1'b1;
        pulse(16, 16'h0014);
        check("pushpop_status", la1_data_out, 32'h0031_0001);
        pulse(18, 16'h0);
        wait_idle(50);
        check("pushpop_count", log_q.size() - n0, 5);
        for (int i = 0; i < 5; i++) check("pushpop_word", get_log(n0 + i), {15'(i), 16'h0010 + 16'(i)});

        // restart while words are queued
        load_ready = 1'b0;
        pulse(17, 16'h0);
        pulse(16, 16'h0021);
        pulse(16, 16'h0022);
        check("restart_before", la1_data_out, 32'h0009_0000);
        pulse(17, 16'h0);
        check("restart_after", la1_data_out, 32'h0001_0000);
        n0 = log_q.size();
        load_ready = 1'b1;
        pulse(16, 16'hBEEF);
        pulse(18, 16'h0);
        wait_idle(50);
        check("restart_count", log_q.size() - n0, 1);
        check("restart_word", get_log(n0), {15'd0, 16'hBEEF});

        // randomized traffic, including restarts, early done and inactive stretches
        pulse(17, 16'h0);
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            load_ready = ($urandom_range(0, 2) != 0);
            if (r < 55)      pulse(16, 16'($urandom));
            else if (r < 58) pulse(17, 16'($urandom));
            else if (r < 60) pulse(18, 16'($urandom));
            else if (r < 65) begin active = ~active; tick(); end
            else             tick();
        end
        active     = 1'b1;
        load_ready = 1'b1;
        pulse(18, 16'h0);
        wait_idle(50);

        // address wrap: one word per cycle across the full address space
        n0 = log_q.size();
        pulse(17, 16'h0);
        for (int i = 0; i <= 32768; i++) pulse(16, 16'(i) ^ 16'h5A5A);
        pulse(18, 16'h0);
        wait_idle(50);
        check("wrap_count", log_q.size() - n0, 32769);
        check("wrap_top", get_log(n0 + 32767), {15'h7FFF, 16'h7FFF ^ 16'h5A5A});
        check("wrap_zero", get_log(n0 + 32768), {15'h0000, 16'h8000 ^ 16'h5A5A});

        // reset mid-drain, then toggles while inactive
        load_ready = 1'b0;
        pulse(17, 16'h0);
        pulse(16, 16'h0031);
        pulse(16, 16'h0032);
        pulse(18, 16'h0);
        check("drain_status", la1_data_out, 32'h000A_0000);
        wb_rst_n = 1'b0;
        #1;
        check("async_rst_valid", load_valid, 0);
        check("async_rst_active", load_active, 0);
        check("async_rst_addr", load_addr, 0);
        check("async_rst_data", load_data, 0);
        check("async_rst_status", la1_data_out, 0);
        tick();
        wb_rst_n = 1'b1;
        active   = 1'b0;
        pulse(17, 16'h0);
        pulse(16, 16'h0041);
        pulse(18, 16'h0);
        pulse(16, 16'h0042);
        check("inactive_status", la1_data_out, 0);
        check("inactive_active", load_active, 0);
        active = 1'b1;
        n0 = log_q.size();
        repeat (3) tick();
        check("reactivate_status", la1_data_out, 0);
        check("reactivate_count", log_q.size() - n0, 0);
        load_ready = 1'b1;
        pulse(17, 16'h0);
        pulse(16, 16'h0077);
        pulse(18, 16'h0);
        wait_idle(50);
        check("post_rst_word", get_log(n0), {15'd0, 16'h0077});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
